// File: rtl/cpu_pkg.sv
// Shared CPU encodings: addressing modes used by operand fetch/store, and the
// operand-store state enum.
package cpu_pkg;

   typedef enum logic [1:0] {
      MODE_IMM   = 2'b00,
      MODE_DIR   = 2'b01,
      MODE_INDIR = 2'b10,
      MODE_REG   = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PTR_RD = 3'd1,
      ST_RAM_WR = 3'd2,
      ST_REG_WR = 3'd3,
      ST_FIN    = 3'd4
   } store_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/operand_store.sv
// Writes a result to RAM or the register file by destination addressing mode.
// Latency start->done: INDIR 3, DIR/REG 2, IMM 1 (err); start is ignored while busy.
module operand_store
   import cpu_pkg::*;
#(
   parameter int MODE_WIDTH     = 2,
   parameter int OPERAND_WIDTH  = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int RAM_ADDR_WIDTH = 8,
   parameter int RAM_DATA_WIDTH = 8,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int REG_DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [MODE_WIDTH-1:0]     mode,
   input  logic [OPERAND_WIDTH-1:0]  operand_in,
   input  logic [DATA_WIDTH-1:0]     data_in,
   input  logic [REG_DATA_WIDTH-1:0] reg_rdata,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
   output logic [RAM_DATA_WIDTH-1:0] ram_wdata,
   output logic                      ram_we,
   output logic [REG_ADDR_WIDTH-1:0] reg_addr,
   output logic [REG_DATA_WIDTH-1:0] reg_wdata,
   output logic                      reg_we
);

   // Common width wide enough to zero-extend any source before slicing to a destination.
   localparam int EXT_W = max_int(max_int(max_int(OPERAND_WIDTH, DATA_WIDTH),
                                          max_int(REG_DATA_WIDTH, RAM_ADDR_WIDTH)),
                                  max_int(RAM_DATA_WIDTH, REG_ADDR_WIDTH));

   store_state_e r_state;
   store_state_e w_next;

   logic [MODE_WIDTH-1:0]     r_mode;
   logic [OPERAND_WIDTH-1:0]  r_operand;
   logic [DATA_WIDTH-1:0]     r_data;
   logic [RAM_ADDR_WIDTH-1:0] r_ptr;

   logic [EXT_W-1:0] w_op_ext;
   logic [EXT_W-1:0] w_data_ext;
   logic [EXT_W-1:0] w_rdata_ext;

   logic w_in_dir, w_in_indir, w_in_reg;
   logic w_lat_dir, w_lat_indir, w_lat_reg;

   assign w_op_ext    = EXT_W'(r_operand);
   assign w_data_ext  = EXT_W'(r_data);
   assign w_rdata_ext = EXT_W'(reg_rdata);

   assign w_in_dir    = (mode == MODE_WIDTH'(MODE_DIR));
   assign w_in_indir  = (mode == MODE_WIDTH'(MODE_INDIR));
   assign w_in_reg    = (mode == MODE_WIDTH'(MODE_REG));

   assign w_lat_dir   = (r_mode == MODE_WIDTH'(MODE_DIR));
   assign w_lat_indir = (r_mode == MODE_WIDTH'(MODE_INDIR));
   assign w_lat_reg   = (r_mode == MODE_WIDTH'(MODE_REG));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // IDLE decodes the incoming mode directly so the first step lands one cycle after start.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_in_dir)        w_next = ST_RAM_WR;
               else if (w_in_indir) w_next = ST_PTR_RD;
               else if (w_in_reg)   w_next = ST_REG_WR;
               else                 w_next = ST_FIN;
            end
         end
         ST_PTR_RD: w_next = ST_RAM_WR;
         ST_RAM_WR: w_next = ST_FIN;
         ST_REG_WR: w_next = ST_FIN;
         ST_FIN:    w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (r_state != ST_IDLE);
      done      = 1'b0;
      err       = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      reg_addr  = '0;
      reg_wdata = '0;
      reg_we    = 1'b0;
      case (r_state)
         ST_PTR_RD: begin
            reg_addr = w_op_ext[REG_ADDR_WIDTH-1:0];
         end
         ST_RAM_WR: begin
            ram_we    = 1'b1;
            ram_addr  = w_lat_indir ? r_ptr : w_op_ext[RAM_ADDR_WIDTH-1:0];
            ram_wdata = w_data_ext[RAM_DATA_WIDTH-1:0];
         end
         ST_REG_WR: begin
            reg_we    = 1'b1;
            reg_addr  = w_op_ext[REG_ADDR_WIDTH-1:0];
            reg_wdata = w_data_ext[REG_DATA_WIDTH-1:0];
         end
         ST_FIN: begin
            done = 1'b1;
            err  = !(w_lat_dir || w_lat_indir || w_lat_reg);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode    <= '0;
         r_operand <= '0;
         r_data    <= '0;
         r_ptr     <= '0;
      end else begin
         if (r_state == ST_IDLE && start) begin
            r_mode    <= mode;
            r_operand <= operand_in;
            r_data    <= data_in;
         end
         if (r_state == ST_PTR_RD) begin
            r_ptr <= w_rdata_ext[RAM_ADDR_WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_operand_store.sv
// Randomised and directed checks of operand_store against a cycle-level model
// built from the addressing-mode rules.
module tb_operand_store;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] mode;
   logic [7:0] operand_in;
   logic [7:0] data_in;
   logic [7:0] reg_rdata;
   logic       busy, done, err, ram_we, reg_we;
   logic [7:0] ram_addr, ram_wdata, reg_wdata;
   logic [3:0] reg_addr;

   operand_store dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .operand_in (operand_in),
      .data_in    (data_in),
      .reg_rdata  (reg_rdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_we     (reg_we)
   );

   always #5 clk = ~clk;

   logic [7:0] regfile [16];
   always_comb reg_rdata = regfile[reg_addr];

   // {busy, done, err, ram_we, ram_addr, ram_wdata, reg_we, reg_addr, reg_wdata}
   wire [32:0] w_obs = {busy, done, err, ram_we, ram_addr, ram_wdata, reg_we, reg_addr, reg_wdata};

   logic [32:0] obs [0:4];
   int n_vec = 0;
   int n_err = 0;

   function automatic int latency(input logic [1:0] m);
      case (m)
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 3;
         default: return 2;
      endcase
   endfunction

   // Expected outputs c cycles after start was sampled (c=0: the idle cycle before).
   function automatic logic [32:0] exp_vec(input logic [1:0] m, input logic [7:0] op,
                                           input logic [7:0] d, input int c);
      logic b, dn, e, rwe, gwe;
      logic [7:0] ra, rd, gd;
      logic [3:0] ga;
      int lat;
      b = 0; dn = 0; e = 0; rwe = 0; gwe = 0; ra = 0; rd = 0; gd = 0; ga = 0;
      lat = latency(m);
      if (c >= 1 && c <= lat) b = 1;
      if (c == lat) begin
         dn = 1;
         e  = (m == 2'b00);
      end else if (c == 1 && m == 2'b01) begin
         rwe = 1; ra = op; rd = d;
      end else if (c == 1 && m == 2'b10) begin
         ga = op[3:0];
      end else if (c == 2 && m == 2'b10) begin
         rwe = 1; ra = regfile[op[3:0]]; rd = d;
      end else if (c == 1 && m == 2'b11) begin
         gwe = 1; ga = op[3:0]; gd = d;
      end
      return {b, dn, e, rwe, ra, rd, gwe, ga, gd};
   endfunction

   // Issues one request from IDLE and records outputs for the idle cycle and each busy cycle.
   task automatic drive_txn(input logic [1:0] m, input logic [7:0] op, input logic [7:0] d,
                            input bit hold);
      int lat;
      lat = latency(m);
      @(posedge clk); #1;
      obs[0] = w_obs;
      start = 1'b1; mode = m; operand_in = op; data_in = d;
      for (int c = 1; c <= lat; c++) begin
         @(posedge clk); #1;
         obs[c] = w_obs;
         start = hold;
         mode = 2'($urandom); operand_in = 8'($urandom); data_in = 8'($urandom);
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; mode = 2'b01; operand_in = 8'hFF; data_in = 8'hFF;
      #3;
      n_vec++;
      if (w_obs !== 33'd0) begin
         n_err++;
         $display("FAIL reset_async: got %h expected %h", w_obs, 33'd0);
      end
      start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (w_obs !== 33'd0) begin
            n_err++;
            $display("FAIL reset_hold cyc%0d: got %h expected %h", i, w_obs, 33'd0);
         end
      end
      start = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_dir;
      drive_txn(2'b01, 8'h3C, 8'hA5, 1'b0);
      for (int c = 0; c <= 2; c++) begin
         n_vec++;
         if (obs[c] !== exp_vec(2'b01, 8'h3C, 8'hA5, c)) begin
            n_err++;
            $display("FAIL dir cyc%0d: got %h expected %h", c, obs[c], exp_vec(2'b01, 8'h3C, 8'hA5, c));
         end
      end
   endtask

   task automatic test_indir;
      drive_txn(2'b10, 8'h05, 8'h11, 1'b0);
      for (int c = 0; c <= 3; c++) begin
         n_vec++;
         if (obs[c] !== exp_vec(2'b10, 8'h05, 8'h11, c)) begin
            n_err++;
            $display("FAIL indir cyc%0d: got %h expected %h", c, obs[c], exp_vec(2'b10, 8'h05, 8'h11, c));
         end
      end
   endtask

   task automatic test_reg;
      drive_txn(2'b11, 8'hF7, 8'h42, 1'b0);
      for (int c = 0; c <= 2; c++) begin
         n_vec++;
         if (obs[c] !== exp_vec(2'b11, 8'hF7, 8'h42, c)) begin
            n_err++;
            $display("FAIL reg cyc%0d: got %h expected %h", c, obs[c], exp_vec(2'b11, 8'hF7, 8'h42, c));
         end
      end
   endtask

   task automatic test_imm;
      drive_txn(2'b00, 8'h01, 8'h99, 1'b0);
      for (int c = 0; c <= 1; c++) begin
         n_vec++;
         if (obs[c] !== exp_vec(2'b00, 8'h01, 8'h99, c)) begin
            n_err++;
            $display("FAIL imm cyc%0d: got %h expected %h", c, obs[c], exp_vec(2'b00, 8'h01, 8'h99, c));
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [32:0] e1;
      @(posedge clk); #1;
      start = 1'b1; mode = 2'b10; operand_in = 8'h05; data_in = 8'h11;
      @(posedge clk); #1;
      start = 1'b0;
      e1 = exp_vec(2'b10, 8'h05, 8'h11, 1);
      n_vec++;
      if (w_obs !== e1) begin
         n_err++;
         $display("FAIL rstmid_ptr_rd: got %h expected %h", w_obs, e1);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (w_obs !== 33'd0) begin
         n_err++;
         $display("FAIL rstmid_async: got %h expected %h", w_obs, 33'd0);
      end
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (w_obs !== 33'd0) begin
            n_err++;
            $display("FAIL rstmid_hold cyc%0d: got %h expected %h", i, w_obs, 33'd0);
         end
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_vec++;
         if (w_obs !== 33'd0) begin
            n_err++;
            $display("FAIL rstmid_after cyc%0d: got %h expected %h", i, w_obs, 33'd0);
         end
      end
      drive_txn(2'b10, 8'h05, 8'h11, 1'b0);
      for (int c = 0; c <= 3; c++) begin
         n_vec++;
         if (obs[c] !== exp_vec(2'b10, 8'h05, 8'h11, c)) begin
            n_err++;
            $display("FAIL rstmid_restart cyc%0d: got %h expected %h", c, obs[c], exp_vec(2'b10, 8'h05, 8'h11, c));
         end
      end
   endtask

   task automatic test_busy_ignore;
      logic [1:0] m;
      logic [7:0] op, d;
      for (int t = 0; t < 6; t++) begin
         m = 2'(t % 4); op = 8'($urandom); d = 8'($urandom);
         drive_txn(m, op, d, 1'b1);
         for (int c = 0; c <= latency(m); c++) begin
            n_vec++;
            if (obs[c] !== exp_vec(m, op, d, c)) begin
               n_err++;
               $display("FAIL busy_ignore t%0d cyc%0d: got %h expected %h", t, c, obs[c], exp_vec(m, op, d, c));
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] ms [4];
      logic [7:0] op, d;
      ms[0] = 2'b10; ms[1] = 2'b00; ms[2] = 2'b11; ms[3] = 2'b01;
      for (int t = 0; t < 4; t++) begin
         op = 8'($urandom); d = 8'($urandom);
         drive_txn(ms[t], op, d, 1'b0);
         for (int c = 0; c <= latency(ms[t]); c++) begin
            n_vec++;
            if (obs[c] !== exp_vec(ms[t], op, d, c)) begin
               n_err++;
               $display("FAIL b2b t%0d cyc%0d: got %h expected %h", t, c, obs[c], exp_vec(ms[t], op, d, c));
            end
         end
      end
   endtask

   task automatic test_random;
      logic [1:0] m;
      logic [7:0] op, d;
      for (int i = 0; i < 16; i++) regfile[i] = 8'($urandom);
      for (int t = 0; t < 40; t++) begin
         m = 2'($urandom); op = 8'($urandom); d = 8'($urandom);
         drive_txn(m, op, d, 1'($urandom_range(0, 1)));
         for (int c = 0; c <= latency(m); c++) begin
            n_vec++;
            if (obs[c] !== exp_vec(m, op, d, c)) begin
               n_err++;
               $display("FAIL random t%0d cyc%0d: got %h expected %h", t, c, obs[c], exp_vec(m, op, d, c));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regfile[i] = 8'(i * 17 + 3);
      regfile[5] = 8'h80;
      test_reset();
      test_dir();
      test_indir();
      test_reg();
      test_imm();
      test_reset_mid();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/operand_store.md
OPERAND_STORE -- requirements
Module: operand_store

Interface
REQ-001 SHALL have parameter MODE_WIDTH, default 2, addressing-mode field width.
REQ-002 SHALL have parameter OPERAND_WIDTH, default 8, destination operand field width.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, result data width.
REQ-004 SHALL have parameters RAM_ADDR_WIDTH 8, RAM_DATA_WIDTH 8, REG_ADDR_WIDTH 4 and REG_DATA_WIDTH 8, giving the memory and register-file port widths.
REQ-005 SHALL use one clock, with an asynchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  request strobe, sampled only in IDLE.
REQ-009 mode  input  MODE_WIDTH  destination addressing mode (IMM=00, DIR=01, INDIR=10, REG=11).
REQ-010 operand_in  input  OPERAND_WIDTH  destination operand.
REQ-011 data_in  input  DATA_WIDTH  result to store.
REQ-012 reg_rdata  input  REG_DATA_WIDTH  combinational register-file read data for reg_addr.
REQ-013 busy  output  1  request in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 err  output  1  qualifies done; high means the request was illegal.
REQ-016 ram_addr  output  RAM_ADDR_WIDTH  RAM write address.
REQ-017 ram_wdata  output  RAM_DATA_WIDTH  RAM write data.
REQ-018 ram_we  output  1  RAM write enable.
REQ-019 reg_addr  output  REG_ADDR_WIDTH  register-file address, used for both read and write.
REQ-020 reg_wdata  output  REG_DATA_WIDTH  register write data.
REQ-021 reg_we  output  1  register write enable.

Function
REQ-022 SHALL implement an FSM with the states IDLE, PTR_RD, RAM_WR, REG_WR and FIN.
REQ-023 In IDLE with start=1, SHALL latch mode, operand_in and data_in, and set busy=1 from the next cycle.
REQ-024 IDLE SHALL transition by latched mode: DIR to RAM_WR, INDIR to PTR_RD, REG to REG_WR, IMM to FIN with err set.
REQ-025 In PTR_RD, reg_addr SHALL equal operand[REG_ADDR_WIDTH-1:0], and reg_rdata[RAM_ADDR_WIDTH-1:0] SHALL be captured as the pointer; the next state is RAM_WR.
REQ-026 In RAM_WR, ram_we SHALL be 1 for exactly one cycle; ram_addr SHALL be operand[RAM_ADDR_WIDTH-1:0] for DIR or the pointer for INDIR; ram_wdata SHALL be data[RAM_DATA_WIDTH-1:0]; the next state is FIN.
REQ-027 In REG_WR, reg_we SHALL be 1 for exactly one cycle, with reg_addr = operand[REG_ADDR_WIDTH-1:0] and reg_wdata = data[REG_DATA_WIDTH-1:0]; the next state is FIN.
REQ-028 In FIN, done SHALL be 1 for one cycle and busy SHALL be 1; err SHALL be 1 only for IMM requests; the next state is IDLE.
REQ-029 Latency from start to done SHALL be 3 cycles for INDIR, 2 cycles for DIR and REG, and 1 cycle for IMM.
REQ-030 start while busy=1 SHALL be ignored, and latched values SHALL NOT change.
REQ-031 IMM SHALL never assert ram_we or reg_we.
REQ-032 ram_we and reg_we SHALL never be 1 in the same cycle.
REQ-033 All address, data and enable outputs SHALL be 0 in any state not listed as driving them.
REQ-034 Widths wider than the destination SHALL be truncated to LSBs; narrower widths SHALL be zero-extended.
REQ-035 A new start SHALL be accepted in the cycle after FIN (back-to-back operation).

Reset
REQ-036 On rst_n=0, the state SHALL go to IDLE immediately, independent of clk.
REQ-037 During reset, busy, done, err, ram_we, reg_we and all addresses and data SHALL be 0, and the latches and pointer SHALL be cleared.
REQ-038 Reset in any state SHALL abort the request, and no write enable SHALL assert afterward until a new start.

Structure
REQ-039 The mode encodings IMM, DIR, INDIR and REG SHALL reside in shared package cpu_pkg, also used by the operand fetch path.
REQ-040 The state enum typedef SHALL reside in cpu_pkg.
REQ-041 The block SHALL be single-module with no sub-module; the FSM and the datapath registers SHALL be in one file.

Verification
REQ-042 DIR, operand=0x3C, data=0xA5 -> cycle 1 ram_we=1, ram_addr=0x3C, ram_wdata=0xA5; cycle 2 done=1, err=0.
REQ-043 INDIR, operand=0x05, reg[5]=0x80, data=0x11 -> PTR_RD reg_addr=5; then ram_we=1 at ram_addr=0x80 with data 0x11; done at cycle 3.
REQ-044 REG, operand=0xF7, data=0x42 -> reg_we=1, reg_addr=0x7 (truncated), reg_wdata=0x42; done at cycle 2.
REQ-045 IMM, operand=0x01 -> no write enable; done=1 and err=1 at cycle 1.
REQ-046 rst_n low during PTR_RD -> outputs 0 and no RAM write; start after release completes normally; start pulsed while busy -> ignored.
